micro_sequencer: RTL and testbench

- Parametrised microprogram sequencer. Successor to the fixed-width hand-clocked micro controller.
- Holds the micro-PC (upc) and fetches microwords from an external combinational control-store ROM.
- Computes the next address: increment, jump, opcode dispatch, or return-to-fetch.
- Supports free-run and single-step modes and a hardware breakpoint. Registered control outputs feed the display/LED logic.

---
 rtl/micro_sequencer_if.sv | 22 ++
 rtl/micro_sequencer.sv | 178 +++++++++++++++++
 tb/tb_micro_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer_if
//  Purpose  : Control-store bus between the micro-sequencer and its ROM.
//             The ROM is combinational: rom_data reflects rom_addr in the
//             same cycle.
//  Signals  : rom_addr  - control-store address (driven by the sequencer)
//             rom_data  - microword {ctrl, seq[1:0], next_addr}
//  Modports : master - sequencer side, slave - ROM side
//  Revision : 1.0 - initial release
// ============================================================================
interface micro_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int CTRL_W = 16
);
    logic [ADDR_W-1:0]          rom_addr;
    logic [CTRL_W+2+ADDR_W-1:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : micro_sequencer
//  Purpose  : Parametrised microprogram sequencer. Holds the micro-PC,
//             fetches microwords from a combinational control store and
//             computes the next address (increment / jump / opcode dispatch /
//             return-to-fetch). Supports free-run, single-step and a
//             hardware breakpoint.
//  Ports    : clock      - system clock
//             reset      - asynchronous active-low reset
//             mode       - 1 = run, 0 = single-step
//             step       - debounced step button (asynchronous level)
//             op         - current opcode used for dispatch
//             bp_en      - breakpoint enable
//             bp_addr    - breakpoint micro-address
//             rom_bus    - control-store bus (master side)
//             ctrl_out   - control field of the last executed microword
//             upc        - current micro-PC
//             bp_hit     - breakpoint halt flag
//             exec_count - number of microwords executed (wraps)
//  Notes    : OP_W must not exceed ADDR_W.
//  Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
    parameter int ADDR_W        = 6,
    parameter int CTRL_W        = 16,
    parameter int OP_W          = 6,
    parameter int DISPATCH_BASE = 32,
    parameter int CNT_W         = 16
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              mode,
    input  wire logic              step,
    input  wire logic [OP_W-1:0]   op,
    input  wire logic              bp_en,
    input  wire logic [ADDR_W-1:0] bp_addr,
    micro_sequencer_if.master      rom_bus,
    output logic [CTRL_W-1:0]      ctrl_out,
    output logic [ADDR_W-1:0]      upc,
    output logic                   bp_hit,
    output logic [CNT_W-1:0]       exec_count
);

    localparam logic [1:0] c_seq_inc   = 2'b00;
    localparam logic [1:0] c_seq_jump  = 2'b01;
    localparam logic [1:0] c_seq_disp  = 2'b10;

    localparam logic [ADDR_W-1:0] c_disp_base = ADDR_W'(DISPATCH_BASE);

    // Breakpoint state machine: RUN = advancing freely, BREAK = halted at bp
    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_break = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;

    logic [ADDR_W-1:0] r_upc;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_count;

    logic              r_step_s1;
    logic              r_step_s2;
    logic              r_step_prev;
    logic              w_step_pulse;

    logic              w_bp_hit;
    logic              w_advance;
    logic [ADDR_W-1:0] w_next_upc;

    logic [ADDR_W-1:0] w_next_addr;
    logic [1:0]        w_seq;
    logic [CTRL_W-1:0] w_ctrl;

    // ------------------------------------------------------------------
    // Microword fields
    // ------------------------------------------------------------------
    assign w_next_addr = rom_bus.rom_data[ADDR_W-1:0];
    assign w_seq       = rom_bus.rom_data[ADDR_W+1:ADDR_W];
    assign w_ctrl      = rom_bus.rom_data[CTRL_W+ADDR_W+1:ADDR_W+2];

    // ------------------------------------------------------------------
    // Step button: two-stage synchroniser followed by rising-edge detect.
    // The pulse is combinational off the edge register so the advance
    // lands on the third clock edge after the button rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_step_s1   <= 1'b0;
            r_step_s2   <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_s1   <= step;
            r_step_s2   <= r_step_s1;
            r_step_prev <= r_step_s2;
        end
    end

    assign w_step_pulse = r_step_s2 & ~r_step_prev;

    // A step pulse in run mode merges with the run advance (single advance).
    assign w_advance = (mode & ~w_bp_hit) | w_step_pulse;

    // ------------------------------------------------------------------
    // Next-address selection
    // ------------------------------------------------------------------
    always_comb begin
        w_next_upc = '0;
        case (w_seq)
            c_seq_inc:  w_next_upc = r_upc + ADDR_W'(1);
            c_seq_jump: w_next_upc = w_next_addr;
            c_seq_disp: w_next_upc = c_disp_base + ADDR_W'(op);
            default:    w_next_upc = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: only move on an advance
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_upc   <= '0;
            r_ctrl  <= '0;
            r_count <= '0;
        end else if (w_advance) begin
            r_upc   <= w_next_upc;
            r_ctrl  <= w_ctrl;
            r_count <= r_count + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Breakpoint FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Breakpoint FSM: next state. Leaving run mode or disabling the
    // breakpoint always releases the halt. The step that releases a halt
    // cannot re-arm it, even if it lands on bp_addr again.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (!mode || !bp_en) begin
            w_state_next = c_st_run;
        end else if (r_state == c_st_break) begin
            if (w_step_pulse) begin
                w_state_next = c_st_run;
            end
        end else if (w_advance && (w_next_upc == bp_addr)) begin
            w_state_next = c_st_break;
        end
    end

    // ------------------------------------------------------------------
    // Breakpoint FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_bp_hit = 1'b0;
        if (r_state == c_st_break) begin
            w_bp_hit = 1'b1;
        end
    end

    assign rom_bus.rom_addr = r_upc;
    assign upc              = r_upc;
    assign ctrl_out         = r_ctrl;
    assign exec_count       = r_count;
    assign bp_hit           = w_bp_hit;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_sequencer
//  Purpose  : Directed self-checking bench for micro_sequencer with a
//             behavioural combinational control-store ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

    localparam int ADDR_W = 6;
    localparam int CTRL_W = 16;
    localparam int OP_W   = 6;
    localparam int CNT_W  = 16;
    localparam int W_W    = CTRL_W + 2 + ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic              step;
    logic [OP_W-1:0]   op;
    logic              bp_en;
    logic [ADDR_W-1:0] bp_addr;
    logic [CTRL_W-1:0] ctrl_out;
    logic [ADDR_W-1:0] upc;
    logic              bp_hit;
    logic [CNT_W-1:0]  exec_count;

    logic [W_W-1:0]    rom [64];

    int n_pass;
    int n_total;

    micro_sequencer_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];

    micro_sequencer #(
        .ADDR_W        (ADDR_W),
        .CTRL_W        (CTRL_W),
        .OP_W          (OP_W),
        .DISPATCH_BASE (32),
        .CNT_W         (CNT_W)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .mode       (mode),
        .step       (step),
        .op         (op),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .rom_bus    (bus),
        .ctrl_out   (ctrl_out),
        .upc        (upc),
        .bp_hit     (bp_hit),
        .exec_count (exec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W_W-1:0] mw(input logic [CTRL_W-1:0] c,
                                          input logic [1:0] s,
                                          input logic [ADDR_W-1:0] na);
        return {c, s, na};
    endfunction

    // Every word increments; ctrl = 0x0100 + address
    task automatic load_linear_rom();
        for (int i = 0; i < 64; i++) rom[i] = mw(16'h0100 + 16'(i), 2'b00, 6'd0);
    endtask

    task automatic load_loop_rom();
        for (int i = 0; i < 64; i++) rom[i] = mw(16'h0000, 2'b00, 6'd0);
        rom[0] = mw(16'h0001, 2'b00, 6'd0);
        rom[1] = mw(16'h0002, 2'b00, 6'd0);
        rom[2] = mw(16'h0004, 2'b11, 6'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        mode  = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        load_loop_rom();
        apply_reset();
        n_total++; if (upc !== 6'd0) $display("FAIL reset_upc: got %0d want 0", upc); else n_pass++;
        n_total++; if (ctrl_out !== 16'h0) $display("FAIL reset_ctrl: got %h want 0000", ctrl_out); else n_pass++;
        n_total++; if (bp_hit !== 1'b0) $display("FAIL reset_bp: got %b want 0", bp_hit); else n_pass++;
        n_total++; if (exec_count !== 16'h0) $display("FAIL reset_cnt: got %h want 0000", exec_count); else n_pass++;
    endtask

    task automatic test_run();
        logic [CTRL_W-1:0] exp_ctrl [6];
        logic [ADDR_W-1:0] exp_upc  [6];
        exp_ctrl = '{16'h1, 16'h2, 16'h4, 16'h1, 16'h2, 16'h4};
        exp_upc  = '{6'd1, 6'd2, 6'd0, 6'd1, 6'd2, 6'd0};
        load_loop_rom();
        apply_reset();
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edge_sample();
            n_total++; if (ctrl_out !== exp_ctrl[i]) $display("FAIL run_ctrl[%0d]: got %h want %h", i, ctrl_out, exp_ctrl[i]); else n_pass++;
            n_total++; if (upc !== exp_upc[i]) $display("FAIL run_upc[%0d]: got %0d want %0d", i, upc, exp_upc[i]); else n_pass++;
            n_total++; if (bus.rom_addr !== exp_upc[i]) $display("FAIL run_rom_addr[%0d]: got %0d want %0d", i, bus.rom_addr, exp_upc[i]); else n_pass++;
            n_total++; if (exec_count !== 16'(i + 1)) $display("FAIL run_cnt[%0d]: got %0d want %0d", i, exec_count, i + 1); else n_pass++;
        end
        @(negedge clk);
        mode = 1'b0;
    endtask

    task automatic test_step();
        load_linear_rom();
        apply_reset();
        step = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            edge_sample();
            if (i < 3) begin
                n_total++; if (upc !== 6'd0) $display("FAIL step_early[%0d]: got upc %0d want 0", i, upc); else n_pass++;
            end else begin
                n_total++; if (upc !== 6'd1) $display("FAIL step_held[%0d]: got upc %0d want 1", i, upc); else n_pass++;
            end
        end
        n_total++; if (exec_count !== 16'd1) $display("FAIL step_cnt: got %0d want 1", exec_count); else n_pass++;
        n_total++; if (ctrl_out !== 16'h0100) $display("FAIL step_ctrl: got %h want 0100", ctrl_out); else n_pass++;
        @(negedge clk);
        step = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (upc !== 6'd1) $display("FAIL step_release: got upc %0d want 1", upc); else n_pass++;
    endtask

    task automatic test_dispatch();
        load_linear_rom();
        rom[0] = mw(16'h00D0, 2'b10, 6'd0);
        apply_reset();
        op   = 6'd5;
        mode = 1'b1;
        edge_sample();
        n_total++; if (upc !== 6'd37) $display("FAIL disp_op5: got upc %0d want 37", upc); else n_pass++;
        n_total++; if (ctrl_out !== 16'h00D0) $display("FAIL disp_ctrl: got %h want 00d0", ctrl_out); else n_pass++;
        apply_reset();
        op   = 6'd40;
        mode = 1'b1;
        edge_sample();
        n_total++; if (upc !== 6'd8) $display("FAIL disp_op40: got upc %0d want 8", upc); else n_pass++;
        @(negedge clk);
        mode = 1'b0;
    endtask

    task automatic test_breakpoint();
        load_loop_rom();
        apply_reset();
        bp_en   = 1'b1;
        bp_addr = 6'd2;
        mode    = 1'b1;
        edge_sample();
        n_total++; if (upc !== 6'd1 || bp_hit !== 1'b0) $display("FAIL bp_first: got upc %0d bp %b want 1 0", upc, bp_hit); else n_pass++;
        edge_sample();
        n_total++; if (upc !== 6'd2 || bp_hit !== 1'b1) $display("FAIL bp_hit: got upc %0d bp %b want 2 1", upc, bp_hit); else n_pass++;
        repeat (3) edge_sample();
        n_total++; if (upc !== 6'd2 || ctrl_out !== 16'h2 || exec_count !== 16'd2)
            $display("FAIL bp_hold: got upc %0d ctrl %h cnt %0d want 2 0002 2", upc, ctrl_out, exec_count); else n_pass++;
        @(negedge clk);
        step = 1'b1;
        repeat (2) edge_sample();
        n_total++; if (upc !== 6'd2 || bp_hit !== 1'b1) $display("FAIL bp_step_wait: got upc %0d bp %b want 2 1", upc, bp_hit); else n_pass++;
        edge_sample();
        n_total++; if (upc !== 6'd0 || ctrl_out !== 16'h4 || bp_hit !== 1'b0 || exec_count !== 16'd3)
            $display("FAIL bp_step: got upc %0d ctrl %h bp %b cnt %0d want 0 0004 0 3", upc, ctrl_out, bp_hit, exec_count); else n_pass++;
        @(negedge clk);
        step = 1'b0;
        @(posedge clk); #1;
        n_total++; if (upc !== 6'd1) $display("FAIL bp_resume: got upc %0d want 1", upc); else n_pass++;
        edge_sample();
        n_total++; if (upc !== 6'd2 || bp_hit !== 1'b1) $display("FAIL bp_rehit: got upc %0d bp %b want 2 1", upc, bp_hit); else n_pass++;
        @(negedge clk);
        mode = 1'b0;
        edge_sample();
        n_total++; if (bp_hit !== 1'b0 || upc !== 6'd2) $display("FAIL bp_mode_clear: got bp %b upc %0d want 0 2", bp_hit, upc); else n_pass++;
        // Re-arm in run mode, then drop bp_en
        @(negedge clk);
        mode = 1'b1;
        repeat (3) edge_sample();
        n_total++; if (bp_hit !== 1'b1 || upc !== 6'd2) $display("FAIL bp_rearm: got bp %b upc %0d want 1 2", bp_hit, upc); else n_pass++;
        @(negedge clk);
        bp_en = 1'b0;
        edge_sample();
        n_total++; if (bp_hit !== 1'b0) $display("FAIL bp_en_clear: got %b want 0", bp_hit); else n_pass++;
        @(negedge clk);
        mode = 1'b0;
    endtask

    task automatic test_wrap();
        load_linear_rom();
        apply_reset();
        bp_en = 1'b0;
        mode  = 1'b1;
        repeat (63) @(posedge clk);
        #1;
        n_total++; if (upc !== 6'd63) $display("FAIL wrap_upc63: got %0d want 63", upc); else n_pass++;
        edge_sample();
        n_total++; if (upc !== 6'd0 || ctrl_out !== 16'h013F) $display("FAIL wrap_upc0: got upc %0d ctrl %h want 0 013f", upc, ctrl_out); else n_pass++;
        repeat (65535 - 64) @(posedge clk);
        #1;
        n_total++; if (exec_count !== 16'hFFFF) $display("FAIL wrap_cnt_max: got %h want ffff", exec_count); else n_pass++;
        edge_sample();
        n_total++; if (exec_count !== 16'h0000) $display("FAIL wrap_cnt_zero: got %h want 0000", exec_count); else n_pass++;
        @(negedge clk);
        mode = 1'b0;
    endtask

    task automatic test_async_reset();
        load_linear_rom();
        apply_reset();
        bp_en   = 1'b1;
        bp_addr = 6'd17;
        mode    = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        n_total++; if (upc !== 6'd17 || bp_hit !== 1'b1) $display("FAIL arst_pre: got upc %0d bp %b want 17 1", upc, bp_hit); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (upc !== 6'd0 || ctrl_out !== 16'h0 || bp_hit !== 1'b0 || exec_count !== 16'h0 || bus.rom_addr !== 6'd0)
            $display("FAIL arst_immediate: got upc %0d ctrl %h bp %b cnt %0d want 0 0000 0 0", upc, ctrl_out, bp_hit, exec_count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        edge_sample();
        n_total++; if (upc !== 6'd1 || ctrl_out !== 16'h0100 || exec_count !== 16'd1)
            $display("FAIL arst_restart: got upc %0d ctrl %h cnt %0d want 1 0100 1", upc, ctrl_out, exec_count); else n_pass++;
        @(negedge clk);
        mode  = 1'b0;
        bp_en = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        mode    = 1'b0;
        step    = 1'b0;
        op      = '0;
        bp_en   = 1'b0;
        bp_addr = '0;
        load_loop_rom();

        test_reset();
        test_run();
        test_step();
        test_dispatch();
        test_breakpoint();
        test_wrap();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
